rs_pe_array: RTL and testbench
==============================

// Module: rs_pe_array
// PURPOSE
//  Parametrised row-stationary MAC array; successor to the dummy-PE array.
//  - NUM_ROWS x NUM_COLS signed MAC PEs, each holding one stationary weight.
//  - Ifmaps shift diagonally; partial sums flow down each column.
//  - Adds serial weight load, a control FSM, valid/ready handshakes and output backpressure.
//  - Sits between the global-buffer read engine and the psum writeback path.
// PARAMETERS
//  DATA_W    8   signed ifmap/weight width (two's complement)
//  PSUM_W    24  signed psum width; elaboration error if < 2*DATA_W+$clog2(NUM_ROWS)
//  NUM_ROWS  3   PE rows (N), >= 2
//  NUM_COLS  3   PE columns (M), >= 2
//  LEN_W     16  width of cfg_len
// PORTS
//  clk            in   1                    clock, rising edge
//  rst            in   1                    reset, asynchronous, active-high
//  cfg_start      in   1                    start pulse; sampled only in IDLE
//  cfg_len        in   LEN_W                ifmap beats per run; latched on load->compute
//  cfg_ifmap_sel  in   NUM_ROWS-1           bit k=1: row k+1 col0 fed from row k last-col output
//  w_valid        in   1                    weight beat valid
//  w_ready        out  1                    weight beat accepted
//  w_data         in   DATA_W               weight, row-major order (r*NUM_COLS+c)
//  if_valid       in   1                    ifmap beat valid
//  if_ready       out  1                    ifmap beat accepted
//  if_col_in      in   DATA_W x[NUM_ROWS]   col-0 ifmap per row
//  if_row_in      in   DATA_W x[NUM_COLS-1] row-0 ifmap for cols 1..M-1
//  psum_valid     out  1                    psum_out valid
//  psum_ready     in   1                    downstream accepts psum
//  psum_out       out  PSUM_W x[NUM_COLS]   bottom-row psums, one per column
//  busy           out  1                    high whenever state != IDLE
// BEHAVIOUR
//  Reset:
//  - All outputs 0.
//  - Weights, PE registers, valid pipeline and counters 0; state IDLE.
//  - Reset mid-run aborts the run; no residual psum_valid afterwards.
//  Stall:
//  - stall = psum_valid & ~psum_ready.
//  - While stalled, every PE, valid and counter register holds.
//  FSM:
//  - IDLE: cfg_start=1 -> LOAD_W; weight index cleared. cfg_start in any other state is ignored.
//  - LOAD_W: w_ready=1. Each w_valid&w_ready writes weight[idx] and increments idx.
//    On idx==N*M-1 accepted: beat_cnt<=cfg_len, then COMPUTE (or DRAIN if cfg_len==0).
//  - COMPUTE: if_ready = ~stall. Each accepted beat injects data and a valid token at row 0
//    and decrements beat_cnt. Last beat accepted -> DRAIN.
//    Cycles with no beat inject 0 data and valid=0.
//  - DRAIN: if_ready=0. Inject bubbles for NUM_ROWS non-stalled cycles, then IDLE.
//  PE (per cycle, gated by ~stall):
//  - if_out <= if_in.
//  - psum_out <= psum_in + sext(if_in)*sext(w). Row 0 psum_in = 0.
//  - Full-width signed arithmetic, wraps at PSUM_W; no saturation.
//  Interconnect:
//  - if_in[p+1][q+1] = if_out[p][q].
//  - if_in[0][q+1] = if_row_in[q].
//  - if_in[0][0] = if_col_in[0].
//  - if_in[k+1][0] = cfg_ifmap_sel[k] ? if_out[k][M-1] : if_col_in[k+1].
//  Latency and ordering:
//  - Beat accepted at cycle t -> psum_valid at t+NUM_ROWS (no stall).
//  - Valid shift register has depth NUM_ROWS, aligned with the psum rows.
//  - psum_out holds stable while psum_valid & ~psum_ready; no beat is lost or duplicated.
//  Other:
//  - w_ready=0 and if_ready=0 outside their states; valid beats are then ignored.
//  - cfg_ifmap_sel must be static during a run; changes take effect immediately (unchecked).
// STRUCTURE
//  - Package rs_pe_array_pkg: state_t enum {IDLE,LOAD_W,COMPUTE,DRAIN};
//    function min_psum_w(DATA_W,NUM_ROWS).
//  - Sub-module rs_pe: one MAC PE (weight reg, if reg, psum reg, enable, weight write strobe).
//    Instanced via generate.
//  - Top level holds the FSM, counters, valid pipeline and interconnect.
// TESTING
//  1. Weights all 1, if_col_in/if_row_in all 2, sel=0, len=1.
//     -> single psum_valid at accept+3; each psum_out=6.
//  2. Weights all -1, ifmaps 127, len=1.
//     -> psum_out = -381 per column (sign extension checked).
//  3. len=8 ramp data, psum_ready low 5 cycles mid-stream.
//     -> if_ready low those cycles; exactly 8 psum beats, in order, match model.
//  4. sel=2'b11, random weights/ifmaps, len=16.
//     -> row k+1 col0 uses row k col2 output; all psums match scoreboard.
//  5. len=0.
//     -> LOAD_W->DRAIN->IDLE, psum_valid never asserted, busy falls after 3 drain cycles.
//  6. rst pulse mid-COMPUTE, and cfg_start pulsed during COMPUTE.
//     -> reset: all outputs 0, IDLE next cycle.
//     -> start pulse: no state change, run completes normally.

Source files
------------

// File: rtl/rs_pe_array_pkg.sv
// Shared types and elaboration helpers for the row-stationary PE array.
package rs_pe_array_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_W  = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   function automatic int min_psum_w(input int data_w, input int num_rows);
      return 2 * data_w + $clog2(num_rows);
   endfunction

endpackage

// File: rtl/rs_pe_array_if.sv
// Weight, ifmap and psum handshake bundle between the array and its neighbours.
interface rs_pe_array_if #(
   parameter int DATA_W   = 8,
   parameter int PSUM_W   = 24,
   parameter int NUM_ROWS = 3,
   parameter int NUM_COLS = 3
);
   import rs_pe_array_pkg::*;

   logic                                w_valid;
   logic                                w_ready;
   logic [DATA_W-1:0]                   w_data;
   logic                                if_valid;
   logic                                if_ready;
   logic [NUM_ROWS-1:0][DATA_W-1:0]     if_col_in;
   logic [NUM_COLS-2:0][DATA_W-1:0]     if_row_in;
   logic                                psum_valid;
   logic                                psum_ready;
   logic [NUM_COLS-1:0][PSUM_W-1:0]     psum_out;

   modport master (
      output w_valid, w_data, if_valid, if_col_in, if_row_in, psum_ready,
      input  w_ready, if_ready, psum_valid, psum_out
   );

   modport slave (
      input  w_valid, w_data, if_valid, if_col_in, if_row_in, psum_ready,
      output w_ready, if_ready, psum_valid, psum_out
   );

endinterface

// File: rtl/rs_pe_array_pe.sv
// One signed MAC processing element holding a stationary weight.
module rs_pe
   import rs_pe_array_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PSUM_W = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic                     w_we_i,
   input  logic signed [DATA_W-1:0] w_i,
   input  logic signed [DATA_W-1:0] if_i,
   input  logic signed [PSUM_W-1:0] psum_i,
   output logic signed [DATA_W-1:0] if_o,
   output logic signed [PSUM_W-1:0] psum_o
);

   logic signed [DATA_W-1:0]   w_q;
   logic signed [DATA_W-1:0]   if_q;
   logic signed [PSUM_W-1:0]   psum_q;
   logic signed [2*DATA_W-1:0] if_ext_s;
   logic signed [2*DATA_W-1:0] w_ext_s;
   logic signed [2*DATA_W-1:0] prod_s;
   logic signed [PSUM_W-1:0]   prod_ext_s;

   assign if_ext_s   = {{DATA_W{if_i[DATA_W-1]}}, if_i};
   assign w_ext_s    = {{DATA_W{w_q[DATA_W-1]}}, w_q};
   assign prod_s     = if_ext_s * w_ext_s;
   assign prod_ext_s = {{(PSUM_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};

   // Stationary weight register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q <= '0;
      end else if (w_we_i) begin
         w_q <= w_i;
      end
   end

   // Ifmap forward and psum accumulate; wraps at PSUM_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_q   <= '0;
         psum_q <= '0;
      end else if (en_i) begin
         if_q   <= if_i;
         psum_q <= psum_i + prod_ext_s;
      end
   end

   assign if_o   = if_q;
   assign psum_o = psum_q;

endmodule

// File: rtl/rs_pe_array.sv
// Row-stationary MAC array: control FSM, valid pipeline and PE interconnect.
module rs_pe_array
   import rs_pe_array_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int PSUM_W   = 24,
   parameter int NUM_ROWS = 3,
   parameter int NUM_COLS = 3,
   parameter int LEN_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic [LEN_W-1:0]    cfg_len,
   input  logic [NUM_ROWS-2:0] cfg_ifmap_sel,
   rs_pe_array_if.slave        bus,
   output logic                busy
);

   localparam int NUM_PE = NUM_ROWS * NUM_COLS;
   localparam int IDX_W  = $clog2(NUM_PE);
   localparam int DRN_W  = $clog2(NUM_ROWS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PE - 1);
   localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(NUM_ROWS - 1);

   if (PSUM_W < min_psum_w(DATA_W, NUM_ROWS)) begin : g_bad_psum_w
      $error("rs_pe_array: PSUM_W too narrow for DATA_W/NUM_ROWS");
   end
   if (NUM_ROWS < 2 || NUM_COLS < 2) begin : g_bad_dims
      $error("rs_pe_array: NUM_ROWS and NUM_COLS must be >= 2");
   end

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [LEN_W-1:0]      beat_q, beat_d;
   logic [DRN_W-1:0]      drain_q, drain_d;
   logic [NUM_ROWS-1:0]   vld_q;
   logic                  busy_q;
   logic                  stall_s, w_acc_s, if_acc_s;

   logic signed [DATA_W-1:0] if_in_s   [NUM_ROWS][NUM_COLS];
   logic signed [DATA_W-1:0] if_out_s  [NUM_ROWS][NUM_COLS];
   logic signed [PSUM_W-1:0] psum_in_s [NUM_ROWS][NUM_COLS];
   logic signed [PSUM_W-1:0] psum_s    [NUM_ROWS][NUM_COLS];

   assign stall_s      = vld_q[NUM_ROWS-1] & ~bus.psum_ready;
   assign bus.w_ready  = (state_q == LOAD_W);
   assign bus.if_ready = (state_q == COMPUTE) & ~stall_s;
   assign w_acc_s      = bus.w_valid & bus.w_ready;
   assign if_acc_s     = bus.if_valid & bus.if_ready;
   assign bus.psum_valid = vld_q[NUM_ROWS-1];
   assign busy         = busy_q;

   // Next state and counters; a stall freezes the drain count
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = LOAD_W;
               idx_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD_W: begin
            if (w_acc_s && (idx_q == LAST_IDX)) begin
               beat_d  = cfg_len;
               drain_d = '0;
               state_d = (cfg_len == '0) ? DRAIN : COMPUTE;
            end else if (w_acc_s) begin
               idx_d = idx_q + IDX_W'(1);
            end else begin
               idx_d = idx_q;
            end
         end
         COMPUTE: begin
            if (if_acc_s) begin
               beat_d = beat_q - LEN_W'(1);
               if (beat_q == LEN_W'(1)) begin
                  state_d = DRAIN;
                  drain_d = '0;
               end else begin
                  state_d = COMPUTE;
               end
            end else begin
               beat_d = beat_q;
            end
         end
         DRAIN: begin
            if (!stall_s && (drain_q == LAST_DRN)) begin
               state_d = IDLE;
            end else if (!stall_s) begin
               drain_d = drain_q + DRN_W'(1);
            end else begin
               drain_d = drain_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers and row-aligned valid pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         beat_q  <= '0;
         drain_q <= '0;
         vld_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
         busy_q  <= (state_d != IDLE);
         if (!stall_s) begin
            vld_q <= {vld_q[NUM_ROWS-2:0], if_acc_s};
         end
      end
   end

   // Only row-0 inputs carry the beat; other col-0 rows take if_col_in directly
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
         if (r == 0 && c == 0) begin : g_corner
            assign if_in_s[r][c] = if_acc_s ? bus.if_col_in[0] : '0;
         end else if (r == 0) begin : g_top
            assign if_in_s[r][c] = if_acc_s ? bus.if_row_in[c-1] : '0;
         end else if (c == 0) begin : g_left
            assign if_in_s[r][c] = cfg_ifmap_sel[r-1] ? if_out_s[r-1][NUM_COLS-1]
                                                      : bus.if_col_in[r];
         end else begin : g_diag
            assign if_in_s[r][c] = if_out_s[r-1][c-1];
         end

         if (r == 0) begin : g_psum_top
            assign psum_in_s[r][c] = '0;
         end else begin : g_psum_chain
            assign psum_in_s[r][c] = psum_s[r-1][c];
         end

         rs_pe #(
            .DATA_W (DATA_W),
            .PSUM_W (PSUM_W)
         ) u_pe (
            .clk    (clk),
            .rst    (rst),
            .en_i   (~stall_s),
            .w_we_i (w_acc_s && (idx_q == IDX_W'(r * NUM_COLS + c))),
            .w_i    (bus.w_data),
            .if_i   (if_in_s[r][c]),
            .psum_i (psum_in_s[r][c]),
            .if_o   (if_out_s[r][c]),
            .psum_o (psum_s[r][c])
         );
      end
   end

   // Bottom-row psum registers drive the output bus
   always_comb begin
      bus.psum_out = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         bus.psum_out[c] = psum_s[NUM_ROWS-1][c];
      end
   end

endmodule

// File: tb/tb_rs_pe_array.sv
// Randomized scoreboard bench for rs_pe_array against a dataflow reference model.
module tb_rs_pe_array;

   localparam int DW = 8;
   localparam int PW = 24;
   localparam int N  = 3;
   localparam int M  = 3;
   localparam int LW = 16;
   localparam int HMAX = 8192;

   typedef logic [M-1:0][PW-1:0] pvec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_start;
   logic [LW-1:0] cfg_len;
   logic [N-2:0]  sel;
   logic          busy;

   rs_pe_array_if #(.DATA_W(DW), .PSUM_W(PW), .NUM_ROWS(N), .NUM_COLS(M)) bus_if ();

   rs_pe_array #(.DATA_W(DW), .PSUM_W(PW), .NUM_ROWS(N), .NUM_COLS(M), .LEN_W(LW)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_len       (cfg_len),
      .cfg_ifmap_sel (sel),
      .bus           (bus_if.slave),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0, n_err = 0;
   int    cyc = 0;
   int    ecyc = 0;
   int    widx = 0;
   int    wm [N][M];
   int    hcol [HMAX][N];
   int    hrow [HMAX][M-1];
   bit    hval [HMAX];
   bit    acc;
   pvec_t exp_q [$];
   pvec_t last_psum;
   int    n_pop = 0, n_stall = 0;
   int    last_acc_cyc = 0, last_pop_cyc = 0, last_w_cyc = 0;
   bit    rnd_rdy = 1'b0;
   int    lo_start = -100;

   task automatic check(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Ifmap seen by PE(p,q) on effective cycle c, derived from the interconnect rules
   function automatic int xval(input int p, input int q, input int c);
      if (c < 0) return 0;
      if (p == 0) return (q == 0) ? hcol[c][0] : hrow[c][q-1];
      if (q > 0) return xval(p - 1, q - 1, c - 1);
      if (sel[p-1]) return xval(p - 1, M - 1, c - 1);
      return hcol[c][p];
   endfunction

   function automatic pvec_t expect_at(input int c);
      pvec_t  v;
      longint s;
      v = '0;
      for (int q = 0; q < M; q++) begin
         s = 0;
         for (int p = 0; p < N; p++) s += longint'(wm[p][q]) * longint'(xval(p, q, c + p));
         v[q] = s[PW-1:0];
      end
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rnd_rdy) bus_if.psum_ready = ($urandom_range(0, 3) != 0);
      else         bus_if.psum_ready = !(cyc >= lo_start && cyc < lo_start + 5);
   end

   // Stimulus tracker: records what entered the array and pushes expected psums
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         ecyc = 0;
         foreach (wm[p, q]) wm[p][q] = 0;
      end else begin
         if (bus_if.w_valid && bus_if.w_ready && widx < N * M) begin
            wm[widx / M][widx % M] = int'($signed(bus_if.w_data));
            widx++;
            last_w_cyc = cyc;
         end
         if (!(bus_if.psum_valid && !bus_if.psum_ready) && ecyc < HMAX) begin
            acc = bus_if.if_valid && bus_if.if_ready;
            for (int r = 0; r < N; r++)
               hcol[ecyc][r] = (r > 0 || acc) ? int'($signed(bus_if.if_col_in[r])) : 0;
            for (int q = 0; q < M - 1; q++)
               hrow[ecyc][q] = acc ? int'($signed(bus_if.if_row_in[q])) : 0;
            hval[ecyc] = acc;
            if (acc) last_acc_cyc = cyc;
            if (ecyc >= N - 1 && hval[ecyc-N+1]) exp_q.push_back(expect_at(ecyc - N + 1));
            ecyc++;
         end
      end
   end

   // Monitor: compares every presented psum beat with the scoreboard head
   always @(negedge clk) begin
      pvec_t e;
      if (!rst) begin
         if (bus_if.psum_valid && !bus_if.psum_ready) begin
            n_stall++;
            check("if_ready_during_stall", bus_if.if_ready, 0);
         end
         if (bus_if.psum_valid && bus_if.psum_ready) begin
            n_pop++;
            last_pop_cyc = cyc;
            last_psum = bus_if.psum_out;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL psum_unexpected: got %h expected no beat", bus_if.psum_out);
            end else begin
               e = exp_q.pop_front();
               if (bus_if.psum_out !== e) begin
                  n_err++;
                  $display("FAIL psum_beat: got %h expected %h", bus_if.psum_out, e);
               end
            end
         end
      end
   end

   task automatic chk_quiet(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_psum_valid"}, bus_if.psum_valid, 0);
      check({tag, "_w_ready"}, bus_if.w_ready, 0);
      check({tag, "_if_ready"}, bus_if.if_ready, 0);
      check({tag, "_psum_out_nonzero"}, longint'(bus_if.psum_out != '0), 0);
   endtask

   task automatic set_data(input int dmode, input int dval, input int i);
      for (int r = 0; r < N; r++)
         if (dmode == 0)      bus_if.if_col_in[r] = DW'(dval);
         else if (dmode == 1) bus_if.if_col_in[r] = DW'(i * 3 + r);
         else                 bus_if.if_col_in[r] = DW'($urandom_range(0, 255));
      for (int q = 0; q < M - 1; q++)
         if (dmode == 0)      bus_if.if_row_in[q] = DW'(dval);
         else if (dmode == 1) bus_if.if_row_in[q] = DW'(i * 5 - q);
         else                 bus_if.if_row_in[q] = DW'($urandom_range(0, 255));
   endtask

   task automatic run(input int len, input int wmode, input int wval, input int dmode,
                      input int dval, input int gap, input bit stall_opt,
                      input int abort_at, input int poke_at);
      int  pop0, k, stall0, cnt;
      bit  ok;
      pop0 = n_pop;
      stall0 = n_stall;
      widx = 0;
      set_data(dmode, dval, 0);
      cfg_start = 1'b1;
      cfg_len = LW'(len);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      for (int i = 0; i < N * M; i++) begin
         bus_if.w_valid = 1'b1;
         bus_if.w_data = (wmode == 0) ? DW'(wval) : DW'($urandom_range(0, 255));
         ok = 1'b0;
         for (k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus_if.w_ready;
         end
         if (!ok) check("w_ready_timeout", 0, 1);
         @(posedge clk); #1;
      end
      bus_if.w_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) begin
            rst = 1'b1;
            bus_if.if_valid = 1'b0;
            #1;
            chk_quiet("async_reset");
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("idle_after_reset_busy", busy, 0);
            cnt = 0;
            repeat (10) @(negedge clk) if (bus_if.psum_valid) cnt++;
            check("no_psum_after_reset", cnt, 0);
            return;
         end
         if (gap > 0) begin
            repeat ($urandom_range(0, gap)) begin
               bus_if.if_valid = 1'b0;
               set_data(2, 0, i);
               @(posedge clk); #1;
            end
         end
         set_data(dmode, dval, i);
         bus_if.if_valid = 1'b1;
         if (i == poke_at) cfg_start = 1'b1;
         ok = 1'b0;
         for (k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = bus_if.if_ready;
         end
         if (!ok) check("if_ready_timeout", 0, 1);
         @(posedge clk); #1;
         bus_if.if_valid = 1'b0;
         if (stall_opt && i == 1) lo_start = cyc + 3;
         if (i == poke_at) begin
            cfg_start = 1'b0;
            @(negedge clk);
            check("start_ignored_w_ready", bus_if.w_ready, 0);
            check("start_ignored_busy", busy, 1);
            @(posedge clk); #1;
         end
      end
      bus_if.if_valid = 1'b0;
      ok = 1'b0;
      for (k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         ok = !busy;
      end
      if (!ok) check("busy_fall_timeout", 0, 1);
      if (len == 0) check("len0_busy_fall_cycles", cyc - last_w_cyc, N + 1);
      check("beat_count", n_pop - pop0, len);
      check("scoreboard_empty", exp_q.size(), 0);
      if (stall_opt) check("stall_cycles", n_stall - stall0, 5);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cfg_start = 1'b0;
      cfg_len = '0;
      sel = '0;
      bus_if.w_valid = 1'b0;
      bus_if.w_data = '0;
      bus_if.if_valid = 1'b0;
      bus_if.if_col_in = '0;
      bus_if.if_row_in = '0;
      bus_if.psum_ready = 1'b1;
      @(negedge clk);
      chk_quiet("reset_state");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Uniform weights and data: exact values and latency
      run(1, 0, 1, 0, 2, 0, 1'b0, -1, -1);
      check("t1_latency", last_pop_cyc - last_acc_cyc, N);
      for (int q = 0; q < M; q++) check("t1_psum", $signed(last_psum[q]), 6);

      run(1, 0, -1, 0, 127, 0, 1'b0, -1, -1);
      for (int q = 0; q < M; q++) check("t2_psum_sign", $signed(last_psum[q]), -381);

      // Ramp stream with a five-cycle backpressure window
      run(8, 1, 0, 1, 0, 0, 1'b1, -1, -1);
      lo_start = -100;

      sel = 2'b11;
      rnd_rdy = 1'b1;
      run(16, 1, 0, 2, 0, 2, 1'b0, -1, -1);
      rnd_rdy = 1'b0;
      sel = 2'b00;

      run(0, 1, 0, 2, 0, 0, 1'b0, -1, -1);

      run(10, 1, 0, 2, 0, 0, 1'b0, 4, -1);

      rnd_rdy = 1'b1;
      run(6, 1, 0, 2, 0, 1, 1'b0, -1, 3);
      sel = 2'b01;
      run(20, 1, 0, 2, 0, 3, 1'b0, -1, -1);
      rnd_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
